// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks the register file read port and streams {index, value} entries over valid/ready
module regfile_dump_reader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32,
    parameter int ZERO_X0    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  rf_ren,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_idx,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);
    localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, CAP = 2'd2, OUT = 2'd3;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_REGS - 1);
    logic [1:0] state, nxt;
    logic [ADDR_WIDTH-1:0] idx;
    logic hs;
    assign hs = out_valid & out_ready;
    assign rf_ren = state == RD;
    assign rf_raddr = idx;
    always_comb nxt = abort ? IDLE : state == IDLE ? (start ? RD : IDLE) : state == RD ? CAP :
                      state == CAP ? OUT : hs ? (out_last ? IDLE : RD) : OUT;
    // busy and out_valid are registered copies of the next-state decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            state     <= nxt;
            busy      <= nxt != IDLE;
            out_valid <= nxt == OUT;
            done      <= state == OUT && hs && out_last && !abort;
            if (state == IDLE && nxt == RD)
                idx <= '0;
            else if (state == OUT && nxt == RD)
                idx <= idx + 1'b1;
            if (state == CAP) begin
                out_data <= (ZERO_X0 != 0 && idx == '0) ? '0 : rf_rdata;
                out_idx  <= idx;
                out_last <= idx == LAST;
            end
        end
    end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: randomized dumps checked against an index/value reference model
module tb_regfile_dump_reader;
    localparam int AW = 5, DW = 64, NR = 32;
    logic clk = 0, rst = 1, start = 0, abort = 0, out_ready = 1;
    logic busy, done, rf_ren, out_valid, out_last;
    logic [AW-1:0] rf_raddr, out_idx;
    logic [DW-1:0] rf_rdata, out_data;
    logic nz_busy, nz_done, nz_ren, nz_valid, nz_last;
    logic [AW-1:0] nz_raddr, nz_idx;
    logic [DW-1:0] nz_rdata, nz_data;
    logic [DW-1:0] regs [NR];
    int n_vec = 0, n_err = 0;

    regfile_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .ZERO_X0(1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
        .rf_ren(rf_ren), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data), .out_last(out_last));

    regfile_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .ZERO_X0(0)) u_nz (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(nz_busy), .done(nz_done),
        .rf_ren(nz_ren), .rf_raddr(nz_raddr), .rf_rdata(nz_rdata), .out_valid(nz_valid),
        .out_ready(out_ready), .out_idx(nz_idx), .out_data(nz_data), .out_last(nz_last));

    always #5 clk = ~clk;

    // register file with one-cycle synchronous read
    always @(posedge clk) begin
        if (rf_ren) rf_rdata <= regs[rf_raddr];
        if (nz_ren) nz_rdata <= regs[nz_raddr];
    end

    task automatic expect_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_val(input int i);
        return i == 0 ? '0 : regs[i];
    endfunction

    task automatic expect_reset_outputs(input string tag);
        expect_eq({tag, "_busy"}, busy, 0);
        expect_eq({tag, "_done"}, done, 0);
        expect_eq({tag, "_ren"}, rf_ren, 0);
        expect_eq({tag, "_raddr"}, rf_raddr, 0);
        expect_eq({tag, "_valid"}, out_valid, 0);
        expect_eq({tag, "_idx"}, out_idx, 0);
        expect_eq({tag, "_data"}, out_data, 0);
        expect_eq({tag, "_last"}, out_last, 0);
    endtask

    // mode: 0 ready high, 1 stall entry 3 for 4 cycles, 2 random ready, 3 start pulses while busy
    task automatic dump(input bit launch, input int mode, input int abort_at, input int rst_at);
        int c, e, stalls, last_hs, stall_cnt, ab_cnt;
        bit fin, ab, in_out;
        c = 0; e = 0; stalls = 0; last_hs = 0; stall_cnt = 0; ab_cnt = 0; fin = 0; ab = 0;
        if (launch) begin
            @(negedge clk);
            start = 1;
        end
        forever begin
            @(posedge clk);
            #1;
            c++;
            start = 0;
            abort = 0;
            in_out = !fin && !ab && c >= last_hs + 3;
            out_ready = mode == 2 ? ($urandom_range(3) != 0) : 1'b1;
            if (mode == 1 && in_out && e == 3 && stall_cnt < 4) begin
                out_ready = 0;
                stall_cnt++;
            end
            if (mode == 3 && in_out && (e == 2 || e == 20)) start = 1;
            if (in_out && e == abort_at) begin
                abort = 1;
                out_ready = 1;
            end
            if (rst_at >= 0 && !ab && e == rst_at && c == last_hs + 2) begin
                #2 rst = 1;
                #1 expect_reset_outputs("async_rst");
                @(posedge clk);
                @(negedge clk);
                rst = 0;
                expect_reset_outputs("post_rst");
                return;
            end
            @(negedge clk);
            if (fin) begin
                expect_eq("done_pulse", done, 1);
                expect_eq("done_cycle", c, 3 * NR + stalls + 1);
                expect_eq("done_busy", busy, 0);
                expect_eq("done_valid", out_valid, 0);
                return;
            end
            if (ab) begin
                expect_eq("abort_busy", busy, 0);
                expect_eq("abort_valid", out_valid, 0);
                expect_eq("abort_done", done, 0);
                expect_eq("abort_ren", rf_ren, 0);
                if (++ab_cnt == 3) return;
                continue;
            end
            expect_eq("busy", busy, 1);
            expect_eq("done_early", done, 0);
            expect_eq("rf_ren", rf_ren, c == last_hs + 1);
            if (c == last_hs + 1) expect_eq("rf_raddr", rf_raddr, e);
            expect_eq("valid", out_valid, in_out);
            if (in_out) begin
                expect_eq("out_idx", out_idx, e);
                expect_eq("out_data", out_data, exp_val(e));
                expect_eq("out_last", out_last, e == NR - 1);
                if (out_ready) begin
                    if (e == 0) expect_eq("nz_data0", nz_data, regs[0]);
                    if (abort) ab = 1;
                    else if (e == NR - 1) fin = 1;
                    else e++;
                    last_hs = c;
                end else stalls++;
            end
            if (c > 600) begin
                expect_eq("timeout", 0, 1);
                return;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) regs[i] = 64'(i) * 64'h1111;
        repeat (2) @(negedge clk);
        expect_reset_outputs("reset");
        rst = 0;
        dump(1, 0, -1, -1);
        dump(1, 1, -1, -1);
        regs[0] = 64'hDEAD_BEEF;
        for (int i = 1; i < NR; i++) regs[i] = {$urandom, $urandom};
        dump(1, 2, -1, -1);
        dump(1, 0, 10, -1);
        dump(1, 2, -1, -1);
        dump(1, 3, -1, -1);
        start = 1;
        dump(0, 0, -1, -1);
        dump(1, 2, -1, 7);
        dump(1, 0, -1, -1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
